// File: rtl/uart_fifo_wr_arb.sv
// uart_fifo_wr_arb
//   Round-robin arbiter that shares one UART TX FIFO write port between
//   NUM_REQ requesters. Each owner gets a bounded burst of MAX_BURST
//   accepted words. Priority rotates after every tenure, and wr is never
//   asserted while the FIFO reports full.
//
//   Optional feature macro: UART_ARB_STALL_RELEASE_EN
//     When defined, an owner that is stalled on full for STALL_LIMIT
//     consecutive cycles is forced to give up its tenure.
//
// Ports
//   clk       system clock, rising edge
//   Reset_n   asynchronous active-low reset
//   req       per-requester write request
//   req_data  packed request data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   full      FIFO full flag
//   wr        FIFO write strobe
//   w_data    data to FIFO RAM (zero when no write)
//   gnt       one-hot accept pulse
//   owner     index of the current or most recent owner
//   busy      high while a tenure (BURST) is active
//
// States
//   IDLE  | no owner; pick the next requester, scanning from rr_ptr
//   BURST | owner may write up to MAX_BURST words; a stall holds the tenure
module uart_fifo_wr_arb #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_BURST   = 4,
    parameter int STALL_LIMIT = 8,
    localparam int OW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          Reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full,
    output logic                          wr,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [OW-1:0]                 owner,
    output logic                          busy
);

    localparam int BW = $clog2(MAX_BURST + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 16 || STALL_LIMIT < 1) begin : g_bad_param
        $error("uart_fifo_wr_arb: parameter out of legal range");
    end

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state;
    logic [OW-1:0]     rr_ptr;
    logic [BW-1:0]     burst_cnt;
`ifdef UART_ARB_STALL_RELEASE_EN
    localparam int SW = $clog2(STALL_LIMIT + 1);
    logic [SW-1:0]     stall_cnt;
`endif

    logic [OW-1:0]         sel_idx;
    logic                  sel_found;
    logic [OW-1:0]         next_rr;
    logic [DATA_WIDTH-1:0] owner_data;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        logic [OW-1:0] idx;
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = OW'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[idx]) begin
                sel_found = 1'b1;
                sel_idx   = idx;
            end
        end
    end

    always_comb begin
        owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == OW'(i)) owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Wrap explicitly: NUM_REQ need not be a power of two.
    assign next_rr = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    assign busy   = (state == BURST);
    assign wr     = busy & req[owner] & ~full;
    assign w_data = wr ? owner_data : '0;

    always_comb begin
        gnt = '0;
        if (wr) gnt[owner] = 1'b1;
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
`ifdef UART_ARB_STALL_RELEASE_EN
            stall_cnt <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        owner     <= sel_idx;
                        burst_cnt <= '0;
`ifdef UART_ARB_STALL_RELEASE_EN
                        stall_cnt <= '0;
`endif
                        state     <= BURST;
                    end
                end
                BURST: begin
                    if (!req[owner]) begin
                        // Release takes priority over a simultaneous full.
                        state  <= IDLE;
                        rr_ptr <= next_rr;
`ifdef UART_ARB_STALL_RELEASE_EN
                        stall_cnt <= '0;
`endif
                    end else if (full) begin
`ifdef UART_ARB_STALL_RELEASE_EN
                        // This stall cycle is the STALL_LIMIT-th in a row.
                        if (stall_cnt == SW'(STALL_LIMIT - 1)) begin
                            state     <= IDLE;
                            rr_ptr    <= next_rr;
                            stall_cnt <= '0;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
`endif
                    end else begin
                        burst_cnt <= burst_cnt + 1'b1;
`ifdef UART_ARB_STALL_RELEASE_EN
                        stall_cnt <= '0;
`endif
                        if (burst_cnt == BW'(MAX_BURST - 1)) begin
                            state  <= IDLE;
                            rr_ptr <= next_rr;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_wr_arb.sv
module tb_uart_fifo_wr_arb;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
    localparam int SL = 8;

    logic            clk = 1'b0;
    logic            Reset_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] req_data = '0;
    logic            full = 1'b0;
    logic            wr;
    logic [DW-1:0]   w_data;
    logic [N-1:0]    gnt;
    logic [1:0]      owner;
    logic            busy;

    int checks = 0;
    int errors = 0;

    uart_fifo_wr_arb #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB), .STALL_LIMIT(SL)
    ) dut (
        .clk(clk), .Reset_n(Reset_n), .req(req), .req_data(req_data), .full(full),
        .wr(wr), .w_data(w_data), .gnt(gnt), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a tenure is either open or not; the owner writes while
    // requesting and not full; the tenure closes after MB words or on a req drop.
    int m_active = 0;
    int m_owner  = 0;
    int m_words  = 0;
    int m_next   = 0;
    int m_stall  = 0;

    task automatic end_tenure();
        m_active = 0;
        m_next   = (m_owner + 1) % N;
    endtask

    always @(negedge clk) begin
        logic          e_wr;
        logic [N-1:0]  e_gnt;
        logic [DW-1:0] e_data;
        logic          found;
        if (!Reset_n) begin
            m_active = 0; m_owner = 0; m_words = 0; m_next = 0; m_stall = 0;
            chk("rst_wr", 32'(wr), 0);
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_wdata", 32'(w_data), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_owner", 32'(owner), 0);
        end else begin
            e_wr   = (m_active != 0) && req[m_owner] && !full;
            e_gnt  = e_wr ? N'(1 << m_owner) : '0;
            e_data = e_wr ? req_data[m_owner*DW +: DW] : '0;
            chk("m_wr", 32'(wr), 32'(e_wr));
            chk("m_gnt", 32'(gnt), 32'(e_gnt));
            chk("m_wdata", 32'(w_data), 32'(e_data));
            chk("m_busy", 32'(busy), 32'(m_active != 0));
            chk("m_owner", 32'(owner), 32'(m_owner));
            if (m_active == 0) begin
                if (req != '0) begin
                    found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        if (!found && req[(m_next + k) % N]) begin
                            found   = 1'b1;
                            m_owner = (m_next + k) % N;
                        end
                    end
                    m_active = 1; m_words = 0; m_stall = 0;
                end
            end else if (!req[m_owner]) begin
                end_tenure();
            end else if (full) begin
`ifdef UART_ARB_STALL_RELEASE_EN
                m_stall++;
                if (m_stall == SL) end_tenure();
`endif
            end else begin
                m_stall = 0;
                m_words++;
                if (m_words == MB) end_tenure();
            end
        end
    end

    logic          wr_s, busy_s;
    logic [N-1:0]  gnt_s;
    logic [DW-1:0] wd_s;
    logic [1:0]    own_s;

    // Capture outputs at the falling edge, then return just after the next rising edge.
    task automatic cyc();
        @(negedge clk);
        wr_s = wr; gnt_s = gnt; wd_s = w_data; busy_s = busy; own_s = owner;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0; req = '0; full = 1'b0;
        cyc(); cyc();
        Reset_n = 1'b1;
    endtask

    task automatic new_data(input int i);
        req_data[i*DW +: DW] = DW'($urandom);
    endtask

    initial begin
        int n;
        int pct;
        logic [N-1:0] eg;

        // First write lands on the second cycle after req.
        do_reset();
        req = 4'b0001; req_data[7:0] = 8'hA5;
        cyc();
        chk("t1_idle_wr", 32'(wr_s), 0);
        chk("t1_idle_busy", 32'(busy_s), 0);
        cyc();
        chk("t1_wr", 32'(wr_s), 1);
        chk("t1_gnt", 32'(gnt_s), 32'h1);
        chk("t1_wdata", 32'(wd_s), 32'hA5);
        chk("t1_busy", 32'(busy_s), 1);
        chk("t1_owner", 32'(own_s), 0);
        req = '0;
        cyc(); cyc();

        // All requesting: 4 words per owner, one idle cycle, rotate 0,1,2,3,0.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < N; i++) new_data(i);
        for (int c = 0; c < 25; c++) begin
            cyc();
            eg = ((c % 5) == 0) ? '0 : N'(1 << ((c / 5) % N));
            chk("t2_rotation_gnt", 32'(gnt_s), 32'(eg));
            for (int i = 0; i < N; i++) if (gnt_s[i]) new_data(i);
        end
        req = '0;
        cyc(); cyc();

        // Stall in the middle of a burst does not consume burst budget.
        do_reset();
        req = 4'b0100; new_data(2);
        cyc();
        chk("t3_idle_busy", 32'(busy_s), 0);
        n = 0;
        for (int c = 0; c < 2; c++) begin
            cyc(); n += int'(gnt_s[2]); new_data(2);
        end
        full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cyc();
            chk("t3_stall_wr", 32'(wr_s), 0);
            chk("t3_stall_gnt", 32'(gnt_s), 0);
            chk("t3_stall_busy", 32'(busy_s), 1);
        end
        full = 1'b0;
        for (int c = 0; c < 2; c++) begin
            cyc(); n += int'(gnt_s[2]); new_data(2);
        end
        req = '0;
        cyc();
        chk("t3_words", 32'(n), 4);
        chk("t3_end_busy", 32'(busy_s), 0);
        cyc();

        // Owner 1 drops after one word; scan resumes at 2 so 3 beats 0.
        do_reset();
        req = 4'b0010; new_data(1);
        cyc(); cyc();
        chk("t4_gnt1", 32'(gnt_s), 32'h2);
        req = 4'b1001; new_data(0); new_data(3);
        cyc();
        chk("t4_drop_busy", 32'(busy_s), 1);
        chk("t4_drop_wr", 32'(wr_s), 0);
        cyc();
        chk("t4_idle_busy", 32'(busy_s), 0);
        cyc();
        chk("t4_owner", 32'(own_s), 3);
        chk("t4_gnt3", 32'(gnt_s), 32'h8);
        req = '0;
        cyc(); cyc();

        // Asynchronous reset mid-burst.
        do_reset();
        req = 4'b1000; new_data(3);
        cyc(); cyc(); new_data(3); cyc(); new_data(3);
        chk("t5_pre_gnt", 32'(gnt_s), 32'h8);
        Reset_n = 1'b0;
        #1;
        chk("t5_async_wr", 32'(wr), 0);
        chk("t5_async_gnt", 32'(gnt), 0);
        chk("t5_async_busy", 32'(busy), 0);
        cyc();
        Reset_n = 1'b1;
        cyc();
        chk("t5_idle_busy", 32'(busy_s), 0);
        cyc();
        chk("t5_owner", 32'(own_s), 3);
        chk("t5_gnt", 32'(gnt_s), 32'h8);
        req = '0;
        cyc(); cyc();

`ifdef UART_ARB_STALL_RELEASE_EN
        // Persistent full: ownership alternates every SL stall cycles plus one idle.
        do_reset();
        req = 4'b0011; new_data(0); new_data(1); full = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cyc();
            chk("t6_wr", 32'(wr_s), 0);
            chk("t6_busy", 32'(busy_s), 32'((c % (SL + 1)) != 0));
            if ((c % (SL + 1)) != 0) chk("t6_owner", 32'(own_s), 32'((c / (SL + 1)) % 2));
        end
        req = '0; full = 1'b0;
        cyc(); cyc();
`endif

        // Randomized traffic under three full densities, checked by the model.
        do_reset();
        for (int phase = 0; phase < 3; phase++) begin
            pct = (phase == 0) ? 0 : (phase == 1) ? 30 : 85;
            for (int c = 0; c < 1000; c++) begin
                cyc();
                for (int i = 0; i < N; i++) begin
                    if (gnt_s[i]) begin
                        new_data(i);
                        if ($urandom_range(0, 3) == 0) req[i] = 1'b0;
                    end else if (!req[i]) begin
                        if ($urandom_range(0, 3) == 0) begin
                            req[i] = 1'b1;
                            new_data(i);
                        end
                    end else if (!(busy && owner == 2'(i)) && $urandom_range(0, 15) == 0) begin
                        req[i] = 1'b0;
                    end
                end
                full = ($urandom_range(0, 99) < pct);
            end
        end
        req = '0; full = 1'b0;
        cyc(); cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
